// File: rtl/irq_ctrl.sv
// Edge-triggered 8-line interrupt controller with fixed lowest-index priority,
// an enable mask and a present/service handshake toward the mcu.
module irq_ctrl #(
  parameter logic [7:0] DEFAULT_MASK = 8'hFF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] req,
  input  logic       ack,
  input  logic       eoi,
  input  logic       mask_we,
  input  logic [7:0] mask_wdata,
  output logic       interrupt,
  output logic [2:0] irq,
  output logic [7:0] pending,
  output logic [7:0] mask,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, PRESENT, SERVICE} state_t;

  state_t     r_state;
  state_t     w_nextState;
  logic [7:0] r_reqPrev;
  logic [7:0] r_pending;
  logic [7:0] r_mask;
  logic       r_armed;
  logic       r_interrupt;
  logic       r_busy;
  logic [2:0] r_irq;
  logic [7:0] w_edge;
  logic [7:0] w_active;
  logic [7:0] w_pendingNext;
  logic [2:0] w_winner;
  logic [2:0] w_irqNext;

  // r_armed suppresses edge detection on the first posedge after reset, so
  // lines already high when reset releases never look like fresh edges.
  assign w_edge   = r_armed ? (req & ~r_reqPrev) : 8'h00;
  assign w_active = r_pending & r_mask;

  always_comb begin
    w_winner = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_active[i]) w_winner = 3'(i);
    end
  end

  // Ack takes precedence over a mask-off in PRESENT; a new edge always wins
  // over the ack clearing the same pending bit.
  always_comb begin
    w_nextState   = r_state;
    w_irqNext     = r_irq;
    w_pendingNext = r_pending;
    case (r_state)
      IDLE: begin
        if (w_active != 8'h00) begin
          w_nextState = PRESENT;
          w_irqNext   = w_winner;
        end
      end
      PRESENT: begin
        if (ack) begin
          w_nextState             = SERVICE;
          w_pendingNext[r_irq]    = 1'b0;
        end else if (!r_mask[r_irq]) begin
          w_nextState = IDLE;
        end
      end
      SERVICE: begin
        if (eoi) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
    w_pendingNext = w_pendingNext | w_edge;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_irq       <= 3'd0;
      r_pending   <= 8'h00;
      r_reqPrev   <= 8'h00;
      r_armed     <= 1'b0;
      r_mask      <= DEFAULT_MASK;
      r_interrupt <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_irq       <= w_irqNext;
      r_pending   <= w_pendingNext;
      r_reqPrev   <= req;
      r_armed     <= 1'b1;
      r_mask      <= mask_we ? mask_wdata : r_mask;
      r_interrupt <= (w_nextState == PRESENT);
      r_busy      <= (w_nextState == SERVICE);
    end
  end

  assign interrupt = r_interrupt;
  assign irq       = r_irq;
  assign pending   = r_pending;
  assign mask      = r_mask;
  assign busy      = r_busy;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: stimulus pushes expected presentations into a
// scoreboard that a negedge monitor pops on every rising interrupt.
module tb_irq_ctrl;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] req;
  logic       ack;
  logic       eoi;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       interrupt;
  logic [2:0] irq;
  logic [7:0] pending;
  logic [7:0] mask;
  logic       busy;

  typedef struct {
    logic [2:0] vec;
    int         cycle;
  } expect_t;

  expect_t    sbQ[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic       prevInt = 1'b0;
  logic [2:0] heldIrq = 3'd0;

  irq_ctrl #(.DEFAULT_MASK(8'hFF)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (req),
    .ack        (ack),
    .eoi        (eoi),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .interrupt  (interrupt),
    .irq        (irq),
    .pending    (pending),
    .mask       (mask),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every rising interrupt must match the oldest expected vector and
  // cycle; while interrupt stays high the vector must not move.
  always @(negedge clock) begin
    expect_t e;
    if (interrupt === 1'b1 && prevInt === 1'b0) begin
      checks++;
      if (sbQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_interrupt got irq=%0d at cycle %0d, required no interrupt", irq, cyc);
      end else begin
        e = sbQ.pop_front();
        if (irq !== e.vec || cyc != e.cycle) begin
          errors++;
          $display("[TB] FAIL presentation got irq=%0d at cycle %0d, required irq=%0d at cycle %0d",
                   irq, cyc, e.vec, e.cycle);
        end
      end
      heldIrq = irq;
    end else if (interrupt === 1'b1 && prevInt === 1'b1) begin
      checks++;
      if (irq !== heldIrq) begin
        errors++;
        $display("[TB] FAIL irq_stable got irq=%0d, required %0d", irq, heldIrq);
      end
    end
    prevInt = interrupt;
  end

  task automatic expectIrq(input logic [2:0] v, input int lat);
    expect_t e;
    e.vec   = v;
    e.cycle = cyc + lat;
    sbQ.push_back(e);
  endtask

  // Drives one cycle of inputs; pulses drop afterwards, req is held.
  task automatic applyStimulus(input logic [7:0] r, input logic a, input logic e,
                               input logic we, input logic [7:0] wd);
    req = r; ack = a; eoi = e; mask_we = we; mask_wdata = wd;
    @(posedge clock);
    #1;
    ack = 1'b0; eoi = 1'b0; mask_we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic expInt, input logic [2:0] expIrq,
                             input logic [7:0] expPend, input logic [7:0] expMask, input logic expBusy);
    checks++;
    if (interrupt !== expInt || irq !== expIrq || pending !== expPend ||
        mask !== expMask || busy !== expBusy) begin
      errors++;
      $display("[TB] FAIL %s got int=%b irq=%0d pend=%h mask=%h busy=%b, required int=%b irq=%0d pend=%h mask=%h busy=%b",
               name, interrupt, irq, pending, mask, busy, expInt, expIrq, expPend, expMask, expBusy);
    end
  endtask

  initial begin
    req = 8'h00; ack = 1'b0; eoi = 1'b0; mask_we = 1'b0; mask_wdata = 8'h00;
    @(posedge clock);
    #1;
    checkOutput("reset_state", 0, 3'd0, 8'h00, 8'hFF, 0);
    idle(1);
    reset_n = 1'b1;
    idle(3);

    // Single line: rise at N, present N+2, ack N+4, eoi N+7.
    expectIrq(3'd2, 2);
    applyStimulus(8'h04, 0, 0, 0, 8'h00);
    checkOutput("single_pending", 0, 3'd0, 8'h04, 8'hFF, 0);
    idle(1);
    checkOutput("single_present", 1, 3'd2, 8'h04, 8'hFF, 0);
    idle(2);
    applyStimulus(8'h04, 1, 0, 0, 8'h00);
    checkOutput("single_ack", 0, 3'd2, 8'h00, 8'hFF, 1);
    idle(2);
    applyStimulus(8'h04, 0, 1, 0, 8'h00);
    checkOutput("single_eoi", 0, 3'd2, 8'h00, 8'hFF, 0);
    applyStimulus(8'h00, 0, 0, 0, 8'h00);

    // Priority: lines 5 and 1 together.
    expectIrq(3'd1, 2);
    applyStimulus(8'h22, 0, 0, 0, 8'h00);
    checkOutput("prio_pending", 0, 3'd2, 8'h22, 8'hFF, 0);
    idle(1);
    checkOutput("prio_first", 1, 3'd1, 8'h22, 8'hFF, 0);
    applyStimulus(8'h22, 1, 0, 0, 8'h00);
    checkOutput("prio_ack", 0, 3'd1, 8'h20, 8'hFF, 1);
    expectIrq(3'd5, 2);
    applyStimulus(8'h22, 0, 1, 0, 8'h00);
    checkOutput("prio_eoi", 0, 3'd1, 8'h20, 8'hFF, 0);
    idle(1);
    checkOutput("prio_second", 1, 3'd5, 8'h20, 8'hFF, 0);
    applyStimulus(8'h22, 1, 0, 0, 8'h00);
    applyStimulus(8'h22, 0, 1, 0, 8'h00);
    checkOutput("prio_done", 0, 3'd5, 8'h00, 8'hFF, 0);
    applyStimulus(8'h00, 0, 0, 0, 8'h00);

    // Mask gating, unmask, then mask-off while presented.
    applyStimulus(8'h00, 0, 0, 1, 8'hFB);
    checkOutput("mask_write", 0, 3'd5, 8'h00, 8'hFB, 0);
    applyStimulus(8'h04, 0, 0, 0, 8'h00);
    checkOutput("mask_gated", 0, 3'd5, 8'h04, 8'hFB, 0);
    idle(2);
    checkOutput("mask_hold", 0, 3'd5, 8'h04, 8'hFB, 0);
    expectIrq(3'd2, 2);
    applyStimulus(8'h04, 0, 0, 1, 8'hFF);
    idle(1);
    checkOutput("mask_present", 1, 3'd2, 8'h04, 8'hFF, 0);
    applyStimulus(8'h04, 0, 0, 1, 8'hFB);
    checkOutput("mask_off_still_up", 1, 3'd2, 8'h04, 8'hFB, 0);
    idle(1);
    checkOutput("mask_off_drop", 0, 3'd2, 8'h04, 8'hFB, 0);
    expectIrq(3'd2, 2);
    applyStimulus(8'h04, 0, 0, 1, 8'hFF);
    idle(1);
    checkOutput("mask_represent", 1, 3'd2, 8'h04, 8'hFF, 0);
    applyStimulus(8'h04, 1, 0, 0, 8'h00);
    checkOutput("mask_ack", 0, 3'd2, 8'h00, 8'hFF, 1);
    applyStimulus(8'h04, 0, 1, 0, 8'h00);
    applyStimulus(8'h00, 0, 0, 0, 8'h00);

    // Collision: fresh edge on line 3 in the ack cycle keeps it pending.
    expectIrq(3'd3, 2);
    applyStimulus(8'h08, 0, 0, 0, 8'h00);
    idle(1);
    checkOutput("coll_present", 1, 3'd3, 8'h08, 8'hFF, 0);
    applyStimulus(8'h00, 0, 0, 0, 8'h00);
    applyStimulus(8'h08, 1, 0, 0, 8'h00);
    checkOutput("coll_ack", 0, 3'd3, 8'h08, 8'hFF, 1);
    expectIrq(3'd3, 2);
    applyStimulus(8'h08, 0, 1, 0, 8'h00);
    checkOutput("coll_eoi", 0, 3'd3, 8'h08, 8'hFF, 0);
    idle(1);
    checkOutput("coll_represent", 1, 3'd3, 8'h08, 8'hFF, 0);
    applyStimulus(8'h08, 1, 0, 0, 8'h00);
    applyStimulus(8'h08, 0, 1, 0, 8'h00);
    applyStimulus(8'h00, 0, 0, 0, 8'h00);

    // Stray strobes, then edges accumulating during service.
    applyStimulus(8'h00, 1, 0, 0, 8'h00);
    checkOutput("stray_ack", 0, 3'd3, 8'h00, 8'hFF, 0);
    expectIrq(3'd0, 2);
    applyStimulus(8'h01, 0, 0, 0, 8'h00);
    idle(1);
    checkOutput("stray_present", 1, 3'd0, 8'h01, 8'hFF, 0);
    applyStimulus(8'h01, 0, 1, 0, 8'h00);
    checkOutput("stray_eoi", 1, 3'd0, 8'h01, 8'hFF, 0);
    applyStimulus(8'h01, 1, 0, 0, 8'h00);
    checkOutput("accum_ack", 0, 3'd0, 8'h00, 8'hFF, 1);
    applyStimulus(8'h41, 0, 0, 0, 8'h00);
    applyStimulus(8'h01, 0, 0, 0, 8'h00);
    applyStimulus(8'h41, 0, 0, 0, 8'h00);
    checkOutput("accum_pending", 0, 3'd0, 8'h40, 8'hFF, 1);
    expectIrq(3'd6, 2);
    applyStimulus(8'h41, 0, 1, 0, 8'h00);
    idle(1);
    checkOutput("accum_present", 1, 3'd6, 8'h40, 8'hFF, 0);
    applyStimulus(8'h41, 1, 0, 0, 8'h00);
    applyStimulus(8'h41, 0, 1, 0, 8'h00);
    checkOutput("accum_done", 0, 3'd6, 8'h00, 8'hFF, 0);
    applyStimulus(8'h00, 0, 0, 0, 8'h00);
    idle(3);

    // Reset in the middle of service with lines held high.
    applyStimulus(8'h00, 0, 0, 1, 8'h7F);
    checkOutput("mask_7f", 0, 3'd6, 8'h00, 8'h7F, 0);
    expectIrq(3'd0, 2);
    applyStimulus(8'h11, 0, 0, 0, 8'h00);
    idle(1);
    checkOutput("rst_present", 1, 3'd0, 8'h11, 8'h7F, 0);
    applyStimulus(8'h11, 1, 0, 0, 8'h00);
    checkOutput("rst_service", 0, 3'd0, 8'h10, 8'h7F, 1);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("rst_async", 0, 3'd0, 8'h00, 8'hFF, 0);
    idle(2);
    reset_n = 1'b1;
    idle(6);
    checkOutput("rst_no_retrigger", 0, 3'd0, 8'h00, 8'hFF, 0);

    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got %0d outstanding presentations, required 0", sbQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter: DEFAULT_MASK, 8'hFF, enable mask loaded at reset (1 = line enabled).
REQ-002 Port: clock  in  1  sole clock; all state updates on posedge.
REQ-003 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-004 Port: req  in  8  level request lines from peripherals (keyboard, screen, timer, ...); synchronous to clock.
REQ-005 Port: ack  in  1  one-cycle pulse from the mcu when it vectors to the interrupt (sets I flag).
REQ-006 Port: eoi  in  1  one-cycle pulse from the mcu on IRET completion.
REQ-007 Port: mask_we  in  1  write strobe for the enable mask.
REQ-008 Port: mask_wdata  in  8  new enable mask value.
REQ-009 Port: interrupt  out  1  request to the mcu; registered.
REQ-010 Port: irq  out  3  vector index of the presented line; registered; stable while interrupt=1.
REQ-011 Port: pending  out  8  latched-edge pending bits (readable status).
REQ-012 Port: mask  out  8  current enable mask.
REQ-013 Port: busy  out  1  high while an interrupt is in service (between ack and eoi).

Function
REQ-014 Each req line SHALL be edge-detected: pending[i] set on the cycle after req[i] goes 0->1 (previous-sample register, reset 0).
REQ-015 pending[i] SHALL set regardless of mask; mask only gates presentation.
REQ-016 Priority SHALL be fixed: lowest index among (pending & mask) wins.
REQ-017 FSM states SHALL be IDLE, PRESENT, SERVICE; reset state IDLE.
REQ-018 IDLE: if (pending & mask) != 0, latch winning index into irq, assert interrupt next cycle, go PRESENT; else stay.
REQ-019 PRESENT: interrupt=1, irq held constant; on ack, clear pending[irq], deassert interrupt, set busy, go SERVICE.
REQ-020 PRESENT without ack: hold indefinitely; a higher-priority arrival SHALL NOT change irq (no preemption once presented).
REQ-021 PRESENT: if the presented line is masked off via mask_we before ack, drop interrupt and return to IDLE next cycle; pending bit retained.
REQ-022 SERVICE: interrupt=0; on eoi, clear busy, go IDLE; next arbitration earliest the cycle after eoi.
REQ-023 ack outside PRESENT and eoi outside SERVICE SHALL be ignored.
REQ-024 New edge on line i in the same cycle ack clears pending[i]: set wins, pending[i]=1 afterwards.
REQ-025 Edges arriving during SERVICE SHALL accumulate in pending; no loss, no count (multiple edges on one line = one pending).
REQ-026 mask_we SHALL update mask next cycle in any state; simultaneous ack still completes normally.
REQ-027 Latency: req rising at cycle N (IDLE, enabled) -> interrupt=1 at N+2.

Reset
REQ-028 reset_n low SHALL immediately force: state IDLE, interrupt=0, irq=0, pending=0, busy=0, mask=DEFAULT_MASK, edge registers=0.
REQ-029 Reset asserted mid-PRESENT or mid-SERVICE SHALL discard the in-flight interrupt; lines still high after release SHALL NOT retrigger (no edge).
REQ-030 First edge detection SHALL occur no earlier than the second posedge after reset_n release.

Verification
REQ-031 Single: req[2] 0->1 at cycle 5 -> interrupt=1, irq=2 at cycle 7; ack at 9 -> interrupt=0, busy=1, pending=0 at 10; eoi at 12 -> busy=0 at 13.
REQ-032 Priority: req[5] and req[1] rise together -> irq=1 first; after ack+eoi, irq=5 presented two cycles after eoi.
REQ-033 Mask: mask=8'hFB, req[2] rises -> pending=8'h04, interrupt stays 0; write mask=8'hFF -> interrupt=1, irq=2 within 2 cycles.
REQ-034 Collision: pending[3]=1 presented, req[3] new edge lands on ack cycle -> after ack pending[3]=1, re-presented after eoi.
REQ-035 Reset mid-SERVICE: busy=1, pending=8'h10, pull reset_n low between edges -> all outputs 0, mask=8'hFF immediately; held-high req lines produce no interrupt after release.
REQ-036 Stray strobes: ack in IDLE, eoi in PRESENT -> no state or output change.
